// File: rtl/array_pkg.sv
// Types and default dimensions shared by the systolic array edge feeders,
// MAC grid and result drain.
package array_pkg;

    localparam int unsigned ARRAY_N = 4;
    localparam int unsigned ARRAY_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } feeder_state_e;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register chain used for one lane of the diagonal skew.
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WD    = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [WD-1:0] din,
    output logic [WD-1:0] dout
);

    logic [WD-1:0] stage_q [DEPTH];
    logic [WD-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = din;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic array: accepts N-lane vectors and emits them
// diagonally skewed, zero-filling stalls and tile tails. Optional feature
// macro: SKEW_FEEDER_BUBBLE_CNT_EN adds the bubble_count output.
module systolic_skew_feeder
    import array_pkg::*;
#(
    parameter int unsigned N     = ARRAY_N,
    parameter int unsigned W     = ARRAY_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*W-1:0]     in_data,
    input  logic               in_last,
    output logic [N*W-1:0]     out_data,
    output logic [N-1:0]       out_active,
    output logic               busy,
    output logic               tile_done,
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    output logic [CNT_W-1:0]   bubble_count,
`endif
    output logic [CNT_W-1:0]   vec_count
);

    localparam int unsigned FC_W = cnt_width(N);
    localparam int unsigned LW   = W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(N - 2);

    feeder_state_e    state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic             tile_done_q, tile_done_d;
    logic             accept;

    logic [LW-1:0] lane_in  [N];
    logic [LW-1:0] lane_out [N];

    assign in_ready  = (state_q != FLUSH);
    assign busy      = (state_q != IDLE);
    assign accept    = in_valid & in_ready;
    assign tile_done = tile_done_q;
    assign vec_count = vec_count_q;

    // Control FSM: tile_done fires on the edge lane N-1 latches the last element.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        vec_count_d = vec_count_q;
        tile_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    vec_count_d = CNT_W'(1);
                    flush_cnt_d = '0;
                    if (in_last) begin
                        if (N == 1) tile_done_d = 1'b1;
                        else        state_d     = FLUSH;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (accept) begin
                    if (vec_count_q != CNT_MAX) vec_count_d = vec_count_q + CNT_W'(1);
                    if (in_last) begin
                        flush_cnt_d = '0;
                        if (N == 1) begin
                            state_d     = IDLE;
                            tile_done_d = 1'b1;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = IDLE;
                    tile_done_d = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + FC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            vec_count_q <= '0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            vec_count_q <= vec_count_d;
            tile_done_q <= tile_done_d;
        end
    end

`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        if (state_q == IDLE && accept) begin
            bubble_d = '0;
        end else if (state_q == STREAM && !in_valid && bubble_q != CNT_MAX) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bubble_q <= '0;
        else       bubble_q <= bubble_d;
    end

    assign bubble_count = bubble_q;
`endif

    // Non-accept edges inject a zero, inactive element so the array keeps moving.
    always_comb begin
        out_data   = '0;
        out_active = '0;
        for (int unsigned i = 0; i < N; i++) begin
            lane_in[i]         = accept ? {1'b1, in_data[i*W +: W]} : '0;
            out_data[i*W +: W] = lane_out[i][W-1:0];
            out_active[i]      = lane_out[i][W];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_delay_line #(
            .DEPTH(g + 1),
            .WD   (LW)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .din  (lane_in[g]),
            .dout (lane_out[g])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (N=4 main instance, N=1 side instance).
module tb_systolic_skew_feeder;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DW    = N * W;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid, in_ready, in_last, busy, tile_done;
    logic [DW-1:0]    in_data, out_data;
    logic [N-1:0]     out_active;
    logic [CNT_W-1:0] vec_count;
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_count;
`endif

    systolic_skew_feeder #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_active(out_active),
        .busy      (busy),
        .tile_done (tile_done),
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
        .bubble_count(bubble_count),
`endif
        .vec_count (vec_count)
    );

    // Single-lane instance
    logic             v1, r1, l1, busy1, done1;
    logic [W-1:0]     d1, od1;
    logic [0:0]       act1;
    logic [CNT_W-1:0] cnt1;
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bub1;
`endif

    systolic_skew_feeder #(.N(1), .W(W), .CNT_W(CNT_W)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v1),
        .in_ready  (r1),
        .in_data   (d1),
        .in_last   (l1),
        .out_data  (od1),
        .out_active(act1),
        .busy      (busy1),
        .tile_done (done1),
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
        .bubble_count(bub1),
`endif
        .vec_count (cnt1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of pushed vectors; lane i shows the push from i edges ago.
    logic [DW-1:0] m_pd [N];
    logic          m_pa [N];
    int            m_blk;
    bit            m_in_tile;
    int unsigned   m_cnt, m_bub;
    int            edge_no, done_edge;
    localparam int unsigned CMAX = (1 << CNT_W) - 1;

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            m_pd[j] = '0;
            m_pa[j] = 1'b0;
        end
        m_blk = 0; m_in_tile = 0; m_cnt = 0; m_bub = 0;
        edge_no = 0; done_edge = -1;
    endtask

    task automatic model_edge(input bit v, input bit l, input logic [DW-1:0] d);
        bit acc;
        acc = v && (m_blk == 0);
        for (int j = N - 1; j > 0; j--) begin
            m_pd[j] = m_pd[j-1];
            m_pa[j] = m_pa[j-1];
        end
        m_pd[0] = acc ? d : '0;
        m_pa[0] = acc;
        if (m_in_tile && !v && m_bub < CMAX) m_bub++;
        if (acc) begin
            if (!m_in_tile) begin
                m_cnt = 1;
                m_bub = 0;
            end else if (m_cnt < CMAX) begin
                m_cnt++;
            end
        end
        edge_no++;
        if (m_blk > 0) m_blk--;
        if (acc && l) begin
            m_in_tile = 0;
            m_blk     = N - 1;
            done_edge = edge_no + N - 1;
        end else if (acc) begin
            m_in_tile = 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [DW-1:0] ed;
        logic [N-1:0]  ea;
        for (int i = 0; i < N; i++) begin
            ed[i*W +: W] = m_pd[i][i*W +: W];
            ea[i]        = m_pa[i];
        end
        chk({tag, ".out_data"},   64'(out_data),   64'(ed));
        chk({tag, ".out_active"}, 64'(out_active), 64'(ea));
        chk({tag, ".in_ready"},   64'(in_ready),   64'(m_blk == 0));
        chk({tag, ".busy"},       64'(busy),       64'(m_in_tile || m_blk > 0));
        chk({tag, ".tile_done"},  64'(tile_done),  64'(edge_no == done_edge));
        chk({tag, ".vec_count"},  64'(vec_count),  64'(m_cnt));
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
        chk({tag, ".bubble_count"}, 64'(bubble_count), 64'(m_bub));
`endif
    endtask

    task automatic step(input string tag, input bit v, input bit l, input logic [DW-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        in_data  = d;
        @(posedge clk);
        model_edge(v, l, d);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        bit            v;
        bit            l;
        logic [DW-1:0] d;
        logic [DW-1:0] ed;
        logic [N-1:0]  ea;
        bit            er;
        bit            edn;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int low_cnt, done_pos, pulses, tiles, k_in_tile;
        logic [DW-1:0] d;
        bit l, acc_pred;

        tbl[0] = '{1'b1, 1'b0, 32'h04030201, 32'h00000001, 4'b0001, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h08070605, 32'h00000205, 4'b0011, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h0c0b0a09, 32'h00030609, 4'b0111, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'hdeadbeef, 32'h04070a00, 4'b1110, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h00000000, 32'h080b0000, 4'b1100, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h00000000, 32'h0c000000, 4'b1000, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 4'b0000, 1'b1, 1'b0};

        in_valid = 0; in_last = 0; in_data = '0;
        v1 = 0; l1 = 0; d1 = '0;
        model_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("reset");

        // Continuous three-vector tile, checked against hand-derived vectors.
        for (int k = 0; k < 7; k++) begin
            step("tbl", tbl[k].v, tbl[k].l, tbl[k].d);
            chk($sformatf("tbl[%0d].data", k),  64'(out_data),   64'(tbl[k].ed));
            chk($sformatf("tbl[%0d].act", k),   64'(out_active), 64'(tbl[k].ea));
            chk($sformatf("tbl[%0d].ready", k), 64'(in_ready),   64'(tbl[k].er));
            chk($sformatf("tbl[%0d].done", k),  64'(tile_done),  64'(tbl[k].edn));
        end
        chk("tbl.vec_count", 64'(vec_count), 64'd3);

        // Same tile with a one-cycle source stall.
        step("gap", 1, 0, 32'h04030201);
        step("gap", 0, 1, 32'hffffffff);
        step("gap", 1, 0, 32'h08070605);
        step("gap", 1, 1, 32'h0c0b0a09);
        for (int k = 0; k < 4; k++) step("gap", 0, 0, '0);
        chk("gap.vec_count", 64'(vec_count), 64'd3);
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
        chk("gap.bubble_count", 64'(bubble_count), 64'd1);
`endif

        // Single-vector tile.
        step("single", 1, 1, 32'h07070707);
        low_cnt  = (in_ready == 1'b0) ? 1 : 0;
        done_pos = -1;
        for (int k = 1; k <= 5; k++) begin
            step("single", 0, 0, '0);
            if (in_ready == 1'b0) low_cnt++;
            if (tile_done) done_pos = k;
        end
        chk("single.ready_low_cycles", 64'(low_cnt), 64'd3);
        chk("single.done_offset", 64'(done_pos), 64'd3);
        chk("single.vec_count", 64'(vec_count), 64'd1);

        // Back-to-back two-vector tiles with source always valid.
        pulses = 0; tiles = 0; k_in_tile = 0; d = $urandom;
        for (int c = 0; c < 30 && tiles < 2; c++) begin
            acc_pred = (m_blk == 0);
            l = (k_in_tile == 1);
            step("b2b", 1, l, d);
            if (tile_done) pulses++;
            if (acc_pred) begin
                d = $urandom;
                if (l) begin
                    k_in_tile = 0;
                    tiles++;
                end else begin
                    k_in_tile++;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            step("b2b", 0, 0, '0);
            if (tile_done) pulses++;
        end
        chk("b2b.done_pulses", 64'(pulses), 64'd2);

        // Reset asserted in FLUSH.
        step("rst", 1, 0, 32'h11223344);
        step("rst", 1, 1, 32'h55667788);
        step("rst", 0, 0, '0);
        @(negedge clk);
        in_valid = 0; in_last = 0;
        reset = 1'b1;
        #1;
        chk("rst.out_data",   64'(out_data),   64'd0);
        chk("rst.out_active", 64'(out_active), 64'd0);
        chk("rst.busy",       64'(busy),       64'd0);
        chk("rst.tile_done",  64'(tile_done),  64'd0);
        chk("rst.vec_count",  64'(vec_count),  64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < N + 1; k++) step("post_rst", 0, 0, '0);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, DW'($urandom));
        end
        for (int k = 0; k < N + 1; k++) step("drain", 0, 0, '0);

        // Single-lane build.
        @(negedge clk);
        v1 = 1; l1 = 0; d1 = 8'h11;
        @(posedge clk); #1;
        chk("n1.a.ready", 64'(r1), 64'd1);
        chk("n1.a.data",  64'(od1), 64'h11);
        chk("n1.a.act",   64'(act1), 64'd1);
        chk("n1.a.done",  64'(done1), 64'd0);
        @(negedge clk);
        l1 = 1; d1 = 8'h22;
        @(posedge clk); #1;
        chk("n1.b.ready", 64'(r1), 64'd1);
        chk("n1.b.data",  64'(od1), 64'h22);
        chk("n1.b.done",  64'(done1), 64'd1);
        chk("n1.b.busy",  64'(busy1), 64'd0);
        chk("n1.b.count", 64'(cnt1), 64'd2);
        @(negedge clk);
        v1 = 0; l1 = 0; d1 = 8'h33;
        @(posedge clk); #1;
        chk("n1.c.done", 64'(done1), 64'd0);
        chk("n1.c.data", 64'(od1), 64'h00);
        chk("n1.c.act",  64'(act1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
